uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO that drains into a UART transmitter with a start/busy handshake.
// Define UART_TX_BUF_OVF_EN to enable the sticky overflow flag on dropped writes.
module uart_tx_buffer #(
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     uart_busy,
  output logic                     tx_send,
  output logic [7:0]               Tx_Data,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            tx_send_reg;
  logic [7:0]      tx_data_reg;
  logic [7:0]      mem [DEPTH];

  logic            wr_accept;
  logic            pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign tx_send = tx_send_reg;
  assign Tx_Data = tx_data_reg;

  // A write against a full FIFO is dropped even when a pop frees a slot that edge.
  assign wr_accept = wr_en & ~full;
  assign pop       = (state_reg == IDLE) & ~empty & ~uart_busy;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (!empty && !uart_busy) state_next = SEND;
      end
      SEND: begin
        timer_next = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A byte that never raises busy is treated as sent; no retry.
        if (uart_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TW'(START_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      tx_send_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      tx_send_reg <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)       rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_reg <= 8'h00;
    end else if (pop) begin
      tx_data_reg <= mem[rd_ptr_reg];
    end
  end

`ifdef UART_TX_BUF_OVF_EN
  logic overflow_reg;
  logic wr_drop;

  assign wr_drop  = wr_en & full;
  assign overflow = overflow_reg;

  // A drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_drop) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer; a queue of expected bytes is checked on every tx_send.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       uart_busy;
  logic       tx_send;
  logic [7:0] tx_data_w;
  logic       overflow;
  logic       ovf_clr;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         tx_seen = 0;
  logic [7:0] exp_q[$];

`ifdef UART_TX_BUF_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  uart_tx_buffer #(.DEPTH(8), .START_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .uart_busy (uart_busy),
    .tx_send   (tx_send),
    .Tx_Data   (tx_data_w),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  // Waits for the start pulse, then plays a UART that is busy for busy_len cycles.
  task automatic serve_byte(input int busy_len);
    int n = 0;
    while (tx_send !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("tx_send_seen", {31'd0, tx_send}, 32'd1);
    uart_busy = 1'b1;
    repeat (busy_len) tick();
    uart_busy = 1'b0;
    tick();
  endtask

  // Scoreboard: every start pulse must carry the oldest accepted byte.
  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", {24'd0, tx_data_w}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'd0, tx_data_w}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    int seen_before;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; uart_busy = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_w}, 32'h00);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Single byte latency
    wr(8'hA5, 1'b1);
    chk("a5_count_after_write", {28'd0, count}, 32'd1);
    chk("a5_no_send_yet", {31'd0, tx_send}, 32'd0);
    tick();
    chk("a5_tx_send", {31'd0, tx_send}, 32'd1);
    chk("a5_tx_data", {24'd0, tx_data_w}, 32'hA5);
    chk("a5_count_popped", {28'd0, count}, 32'd0);
    serve_byte(3);
    chk("a5_empty", {31'd0, empty}, 32'd1);

    // Fill while UART busy
    uart_busy = 1'b1;
    seen_before = tx_seen;
    for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {28'd0, count}, 32'd8);
    chk("fill_no_send", 32'(tx_seen), 32'(seen_before));

    // Drops against a full FIFO
    wr(8'hFF, 1'b0);
    chk("drop_count", {28'd0, count}, 32'd8);
    chk("drop_overflow", {31'd0, overflow}, {31'd0, OVF_EXP});
    ovf_clr = 1'b1;
    wr(8'hFE, 1'b0);
    chk("drop_with_clr_overflow", {31'd0, overflow}, {31'd0, OVF_EXP});
    tick();
    ovf_clr = 1'b0;
    chk("clr_overflow", {31'd0, overflow}, 32'd0);

    // Release busy with a write on the pop edge: write is still dropped
    uart_busy = 1'b0;
    wr(8'hEE, 1'b0);
    chk("pop_drop_count", {28'd0, count}, 32'd7);
    chk("pop_drop_tx_send", {31'd0, tx_send}, 32'd1);
    chk("pop_drop_overflow", {31'd0, overflow}, {31'd0, OVF_EXP});
    for (int i = 0; i < 8; i++) serve_byte(2);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("drain_clr_overflow", {31'd0, overflow}, 32'd0);

    // Start timeout: busy never rises, next byte waits for the return to IDLE
    wr(8'h3C, 1'b1);
    tick();
    chk("to_first_send", {31'd0, tx_send}, 32'd1);
    wr(8'h3D, 1'b1);
    n = 0;
    while (tx_send !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_gap_cycles", 32'(n), 32'd17);
    serve_byte(2);

    // Simultaneous write and pop with count 3; pointers have wrapped by now
    uart_busy = 1'b1;
    wr(8'h51, 1'b1);
    wr(8'h52, 1'b1);
    wr(8'h53, 1'b1);
    chk("wp_count_before", {28'd0, count}, 32'd3);
    uart_busy = 1'b0;
    wr(8'h77, 1'b1);
    chk("wp_count_same", {28'd0, count}, 32'd3);
    chk("wp_tx_send", {31'd0, tx_send}, 32'd1);
    for (int i = 0; i < 4; i++) serve_byte(2);
    chk("wp_queue", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT_DONE with bytes queued; rst overrides a write
    uart_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i), 1'b1);
    uart_busy = 1'b0;
    tick();
    chk("wd_tx_send", {31'd0, tx_send}, 32'd1);
    uart_busy = 1'b1;
    tick();
    tick();
    chk("wd_count", {28'd0, count}, 32'd4);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hCC;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data_w}, 32'h00);
    uart_busy = 1'b0;
    seen_before = tx_seen;
    repeat (4) tick();
    chk("post_rst_no_send", 32'(tx_seen), 32'(seen_before));
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
